// File: rtl/ocp3_nic_sideband_qualifier.sv
// OCP3 NIC sideband qualifier: synchronises and debounces the raw NIC sideband pins,
// tracks card presence, and flags NIC power-good loss while main power is enabled.
module ocp3_nic_sideband_qualifier #(
    parameter logic [15:0] INSERT_MS = 16'd50,
    parameter logic [15:0] REMOVE_MS = 16'd2,
    parameter logic [15:0] PG_MS     = 16'd2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick_1ms,
    input  logic       iPRSNT_NIC_N_RAW,
    input  logic       iPWRGD_NIC_EDGE_RAW,
    input  logic       iPWRGD_NIC_PWR_GOOD_RAW,
    input  logic       iNIC_MAIN_PWR_EN,
    input  logic       iFAULT_CLR,
    output logic       oPRSNT_NIC_N,
    output logic       oPWRGD_NIC_EDGE,
    output logic       oPWRGD_NIC_PWR_GOOD,
    output logic       oPRSNT_CHANGE,
    output logic       oPWRGD_FAULT,
    output logic       oFAULT_LATCHED,
    output logic [1:0] oDBG_PRSNT_FSM
);

    typedef enum logic [1:0] {
        ABSENT   = 2'b00,
        INS_WAIT = 2'b01,
        PRESENT  = 2'b11,
        REM_WAIT = 2'b10
    } prsnt_state_e;

    localparam int PG_EDGE = 0;
    localparam int PG_NIC  = 1;

    // Advance a debounce count by one ms tick, saturating at all-ones.
    function automatic logic [15:0] tick_step(input logic [15:0] value, input logic tick);
        if (!tick || value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

    // Two-flop synchronisers; bit 0 is the metastable stage.
    logic [1:0] prsnt_n_sync;
    logic [1:0] edge_sync;
    logic [1:0] pg_sync;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            prsnt_n_sync <= 2'b11;
            edge_sync    <= 2'b00;
            pg_sync      <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let each stage capture the previous stage's old value.
            prsnt_n_sync <= {prsnt_n_sync[0], iPRSNT_NIC_N_RAW};
            edge_sync    <= {edge_sync[0], iPWRGD_NIC_EDGE_RAW};
            pg_sync      <= {pg_sync[0], iPWRGD_NIC_PWR_GOOD_RAW};
        end
    end

    logic       prsnt_n;
    logic [1:0] pg_in;

    assign prsnt_n = prsnt_n_sync[1];
    assign pg_in   = {pg_sync[1], edge_sync[1]};

    // Presence FSM and its debounce counter.
    prsnt_state_e state;
    prsnt_state_e state_d;
    logic [15:0]  prs_cnt;
    logic [15:0]  prs_cnt_d;
    logic [15:0]  prs_cnt_inc;
    logic         prsnt_n_q;
    logic         prsnt_n_d;
    logic         change_d;
    logic         to_absent;

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        state_d     = state;
        prs_cnt_d   = 16'd0;
        prsnt_n_d   = prsnt_n_q;
        change_d    = 1'b0;
        prs_cnt_inc = tick_step(prs_cnt, iTick_1ms);

        case (state)
            ABSENT: begin
                if (!prsnt_n) begin
                    state_d = INS_WAIT;
                end
            end
            INS_WAIT: begin
                if (prsnt_n) begin
                    state_d = ABSENT;
                end else if (prs_cnt_inc >= INSERT_MS) begin
                    state_d   = PRESENT;
                    prsnt_n_d = 1'b0;
                    change_d  = 1'b1;
                end else begin
                    prs_cnt_d = prs_cnt_inc;
                end
            end
            PRESENT: begin
                if (prsnt_n) begin
                    state_d = REM_WAIT;
                end
            end
            REM_WAIT: begin
                if (!prsnt_n) begin
                    state_d = PRESENT;
                end else if (prs_cnt_inc >= REMOVE_MS) begin
                    state_d   = ABSENT;
                    prsnt_n_d = 1'b1;
                    change_d  = 1'b1;
                end else begin
                    prs_cnt_d = prs_cnt_inc;
                end
            end
            default: begin
                state_d   = ABSENT;
                prsnt_n_d = 1'b1;
            end
        endcase
    end

    assign to_absent = (state_d == ABSENT) && (state != ABSENT);

    // Power-good channels are forced low against the next presence value so the
    // clear lands in the same cycle removal is declared.
    logic [1:0]  pg_q;
    logic [1:0]  pg_d;
    logic [15:0] pg_cnt   [2];
    logic [15:0] pg_cnt_d [2];

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            pg_d[ch]     = pg_q[ch];
            pg_cnt_d[ch] = 16'd0;
            if (prsnt_n_d) begin
                pg_d[ch] = 1'b0;
            end else if (pg_in[ch] != pg_q[ch]) begin
                if (tick_step(pg_cnt[ch], iTick_1ms) >= PG_MS) begin
                    pg_d[ch] = pg_in[ch];
                end else begin
                    pg_cnt_d[ch] = tick_step(pg_cnt[ch], iTick_1ms);
                end
            end
        end
    end

    // A fall with presence still declared is a genuine loss, never the removal clear.
    logic fault_q;
    logic fault_d;
    logic latched_q;
    logic latched_d;

    assign fault_d = pg_q[PG_NIC] && !pg_d[PG_NIC] && !prsnt_n_q && !prsnt_n_d
                     && iNIC_MAIN_PWR_EN;
    assign latched_d = fault_d || (latched_q && !iFAULT_CLR && !to_absent);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ABSENT;
            prs_cnt   <= 16'd0;
            prsnt_n_q <= 1'b1;
            oPRSNT_CHANGE <= 1'b0;
            pg_q      <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                pg_cnt[ch] <= 16'd0;
            end
            fault_q   <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            state     <= state_d;
            prs_cnt   <= prs_cnt_d;
            prsnt_n_q <= prsnt_n_d;
            oPRSNT_CHANGE <= change_d;
            pg_q      <= pg_d;
            for (int ch = 0; ch < 2; ch++) begin
                pg_cnt[ch] <= pg_cnt_d[ch];
            end
            fault_q   <= fault_d;
            latched_q <= latched_d;
        end
    end

    assign oPRSNT_NIC_N        = prsnt_n_q;
    assign oPWRGD_NIC_EDGE     = pg_q[PG_EDGE];
    assign oPWRGD_NIC_PWR_GOOD = pg_q[PG_NIC];
    assign oPWRGD_FAULT        = fault_q;
    assign oFAULT_LATCHED      = latched_q;
    assign oDBG_PRSNT_FSM      = state;

endmodule

// File: doc/ocp3_nic_sideband_qualifier.md
Name: ocp3_nic_sideband_qualifier

Overview:
- Upstream front end for the OCP3 NIC power sequencer.
- Synchronises and debounces the raw NIC sideband pins (present, edge power-good, NIC power-good) into the iClk domain.
- Runs a presence FSM and produces the clean PRSNT_N, PWRGD_EDGE and PWRGD_PWR_GOOD levels the sequencer consumes.
- Flags NIC power-good loss while main power is enabled.

Parameters:
- INSERT_MS, 16'd50: ms ticks that raw present must hold asserted before presence is declared.
- REMOVE_MS, 16'd2: ms ticks that raw present must hold deasserted before removal is declared.
- PG_MS, 16'd2: ms ticks of stability required on each power-good channel, both directions.

Ports:
- iClk  in  1  module clock, 2MHz
- iRst  in  1  asynchronous active-high reset
- iTick_1ms  in  1  single-iClk-cycle pulse once per ms, synchronous to iClk
- iPRSNT_NIC_N_RAW  in  1  raw card-present pin, active-low, asynchronous
- iPWRGD_NIC_EDGE_RAW  in  1  raw edge power-good pin, asynchronous
- iPWRGD_NIC_PWR_GOOD_RAW  in  1  raw NIC power-good pin, asynchronous
- iNIC_MAIN_PWR_EN  in  1  main-power-enable feedback from the sequencer
- iFAULT_CLR  in  1  single-cycle clear for the fault latch
- oPRSNT_NIC_N  out  1  qualified present, active-low
- oPWRGD_NIC_EDGE  out  1  qualified edge power-good
- oPWRGD_NIC_PWR_GOOD  out  1  qualified NIC power-good
- oPRSNT_CHANGE  out  1  one-cycle pulse on every qualified presence change
- oPWRGD_FAULT  out  1  one-cycle pulse on power-good loss under main power
- oFAULT_LATCHED  out  1  sticky fault flag
- oDBG_PRSNT_FSM  out  2  presence FSM state

Behaviour:
- Reset (iRst=1, asynchronous): all sync flops and counters clear; FSM=ABSENT.
  - oPRSNT_NIC_N=1; oPWRGD_NIC_EDGE=0; oPWRGD_NIC_PWR_GOOD=0.
  - oPRSNT_CHANGE=0; oPWRGD_FAULT=0; oFAULT_LATCHED=0; oDBG_PRSNT_FSM=2'b00.
  - Sync flops reset to the inactive level: present_n=1, power-goods=0.
- Synchronisers: each raw input passes through a 2-flop synchroniser. Every later reference to an input means its synced value.
- Debounce counters: 16-bit, incremented only on iTick_1ms while the condition holds.
  - The counter clears in the same cycle the condition drops.
  - The counter saturates at 16'hFFFF.
  - A threshold of 0 means the transition happens on the first iClk after the condition is seen.
- Presence FSM:
  - ABSENT (00): enter INS_WAIT when present_n=0.
  - INS_WAIT (01):
    - present_n=1 -> ABSENT, counter cleared.
    - count reaches INSERT_MS -> PRESENT; oPRSNT_NIC_N<=0; oPRSNT_CHANGE pulses.
  - PRESENT (11): enter REM_WAIT when present_n=1.
  - REM_WAIT (10):
    - present_n=0 -> PRESENT, counter cleared.
    - count reaches REMOVE_MS -> ABSENT; oPRSNT_NIC_N<=1; oPRSNT_CHANGE pulses.
- Power-good channels (edge and NIC, independent):
  - Each output flips once the synced input has differed from it for PG_MS ticks.
  - While oPRSNT_NIC_N=1, both outputs are forced to 0 and their counters are held clear. This applies in the same cycle removal is declared.
  - Debouncing restarts from 0 after presence is declared.
- Fault:
  - oPWRGD_FAULT pulses for 1 cycle when qualified oPWRGD_NIC_PWR_GOOD falls while iNIC_MAIN_PWR_EN=1 and oPRSNT_NIC_N=0, with both sampled in the cycle before the fall.
  - A fall caused by the forced clear on removal is not a fault.
  - oFAULT_LATCHED sets on oPWRGD_FAULT.
  - oFAULT_LATCHED clears on iFAULT_CLR or on the transition to ABSENT.
  - If a new fault and iFAULT_CLR occur in the same cycle, the latch stays set.
- Latency: a raw edge stable for the full window appears at the output 2 iClk plus the ms window later. The window resolution is up to 1 ms early depending on tick phase.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset release with the card present (raw present_n=0) and INSERT_MS=50:
   - oPRSNT_NIC_N stays 1 through tick 49.
   - On tick 50, oPRSNT_NIC_N goes to 0 and oPRSNT_CHANGE pulses once.
   - oDBG_PRSNT_FSM sequence: 00 -> 01 -> 11.
2. Insertion bounce: raw present_n low for 30 ticks, high for 1 tick, then low.
   - FSM returns to ABSENT and the counter restarts.
   - Present is declared 50 ticks after the final low (not 20).
3. NIC power-good with PG_MS=2, card present: raw PWR_GOOD 1 for 1 tick, then 0.
   - Output stays 0.
   - Held at 1 for 2 ticks -> output goes to 1.
4. Power-good loss under main power, with iNIC_MAIN_PWR_EN=1:
   - Raw PWR_GOOD drops for 2 ticks -> one-cycle oPWRGD_FAULT; oFAULT_LATCHED=1.
   - iFAULT_CLR -> latch clears.
   - Repeat with iNIC_MAIN_PWR_EN=0 -> no fault.
5. Removal: card present with both power-goods=1, then raw present_n=1 for 2 ticks.
   - oPRSNT_NIC_N=1 and oPRSNT_CHANGE pulses.
   - Both power-good outputs are 0 in the same cycle.
   - No oPWRGD_FAULT, and the latch is cleared.
6. Async reset asserted mid-INS_WAIT (count 25) with a fault latched:
   - All outputs immediately return to their reset values.
   - After release, insertion needs the full 50 ticks again.
